// File: rtl/sc_bitstream_counter.sv
// rtl/sc_bitstream_counter.sv - counts ones in a fixed window of a stochastic bitstream after a warm-up
module sc_bitstream_counter #(
  parameter int WIN_LOG2 = 8,
  parameter int WARMUP   = 16,
  parameter int OUT_W    = WIN_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic [OUT_W-1:0] out_cnt,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy
);

  // warm_cnt only needs to reach WARMUP-1; keep it at least one bit wide when WARMUP is 0 or 1
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WARM_W-1:0]   WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [WIN_LOG2-1:0] SAMP_LAST = '1;

  typedef enum logic [1:0] {IDLE, WARM, ACC, HOLD} state_t;

  // With no warm-up the first valid bit after start is already a window sample
  localparam state_t FIRST = (WARMUP > 0) ? WARM : ACC;

  state_t              state, state_nx;
  logic [WARM_W-1:0]   warm_cnt, warm_cnt_nx;
  logic [WIN_LOG2-1:0] samp_cnt, samp_cnt_nx;
  logic [OUT_W-1:0]    ones_cnt, ones_cnt_nx;
  logic [OUT_W-1:0]    out_cnt_nx;
  logic                out_vld_nx;
  logic [OUT_W-1:0]    bit_ext;

  assign bit_ext = {{(OUT_W-1){1'b0}}, bit_in};

  // Next-state and counter update; abort overrides start, stream and handshake
  always_comb begin
    state_nx    = state;
    warm_cnt_nx = warm_cnt;
    samp_cnt_nx = samp_cnt;
    ones_cnt_nx = ones_cnt;
    out_cnt_nx  = out_cnt;
    out_vld_nx  = out_vld;
    if (abort) begin
      state_nx    = IDLE;
      warm_cnt_nx = '0;
      samp_cnt_nx = '0;
      ones_cnt_nx = '0;
      out_vld_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            warm_cnt_nx = '0;
            samp_cnt_nx = '0;
            ones_cnt_nx = '0;
            state_nx    = FIRST;
          end
        end
        WARM: begin
          if (bit_vld) begin
            warm_cnt_nx = warm_cnt + WARM_W'(1);
            if (warm_cnt == WARM_LAST) begin
              state_nx = ACC;
            end
          end
        end
        ACC: begin
          if (bit_vld) begin
            samp_cnt_nx = samp_cnt + WIN_LOG2'(1);
            ones_cnt_nx = ones_cnt + bit_ext;
            if (samp_cnt == SAMP_LAST) begin
              out_cnt_nx = ones_cnt + bit_ext;
              out_vld_nx = 1'b1;
              state_nx   = HOLD;
            end
          end
        end
        HOLD: begin
          // A start coinciding with the handshake chains straight into the next window
          if (out_rdy) begin
            out_vld_nx = 1'b0;
            state_nx   = IDLE;
            if (start) begin
              warm_cnt_nx = '0;
              samp_cnt_nx = '0;
              ones_cnt_nx = '0;
              state_nx    = FIRST;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and datapath registers; busy is registered from the next state so it tracks state != IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      warm_cnt <= '0;
      samp_cnt <= '0;
      ones_cnt <= '0;
      out_cnt  <= '0;
      out_vld  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      warm_cnt <= warm_cnt_nx;
      samp_cnt <= samp_cnt_nx;
      ones_cnt <= ones_cnt_nx;
      out_cnt  <= out_cnt_nx;
      out_vld  <= out_vld_nx;
      busy     <= (state_nx != IDLE);
    end
  end

endmodule
